iq_mod: RTL and testbench
=========================

# iq_mod

Transmit-side counterpart of `iq_demod` in the ZigBee datapath. It accepts signed 8-bit baseband I/Q samples through a valid/ready handshake and buffers them in a small FIFO. It mixes them to the fs/4 intermediate frequency and quantizes the result to 4-bit I_IF/Q_IF. Outputs are paced by a self-generated `eoc` strobe, one IF sample every DIV clocks, which is the cadence `iq_demod` consumes.

## Interface
- DIV, 5: clocks per IF sample; legal range 2..15.
- FIFO_DEPTH, 4: baseband FIFO entries; power of two, 2..16.

- clk  in  1  system clock (50 MHz nominal).
- reset_n  in  1  asynchronous active-low reset.
- I_BB  in  8  baseband I, two's complement.
- Q_BB  in  8  baseband Q, two's complement.
- bb_valid  in  1  I_BB/Q_BB hold a sample.
- bb_ready  out  1  FIFO can accept; equals !full.
- eoc  out  1  one-cycle strobe; I_IF/Q_IF updated this cycle.
- I_IF  out  4  IF I sample, two's complement.
- Q_IF  out  4  IF Q sample, two's complement.
- underflow  out  1  one-cycle pulse: tick found FIFO empty.

## Operation
- Push: a sample is written on any edge where bb_valid && bb_ready.
  - bb_ready is registered from the FIFO count.
  - A slot freed by a pop is visible on bb_ready the next cycle.
- Tick counter:
  - cnt counts 0..DIV-1.
  - At cnt==DIV-1 the next edge sets cnt=0 and eoc=1, pops one FIFO entry if non-empty, and loads I_IF/Q_IF.
  - On all other edges eoc=0.
- LO phase p (2 bits):
  - Advances by 1 on every tick, including underflow ticks.
  - Wraps 3→0.
- Mixing of popped (I,Q) by p:
  - p=0: (I, Q)
  - p=1: (−Q, I)
  - p=2: (−I, −Q)
  - p=3: (Q, −I)
- Arithmetic:
  - Negation is done at 9 bits, so −(−128) = +128.
  - Quantization: q = (x + 8) >>> 4, arithmetic.
  - Saturation of q to [−8, 7].
- Empty at tick: I_IF=Q_IF=0 and underflow=1 for that cycle.
- Simultaneous push and tick with FIFO empty:
  - The pop sees empty, so the tick is an underflow.
  - The pushed sample is kept for the next tick.
- Simultaneous push and tick with FIFO partially full: both occur and the count is unchanged.
- No push is possible while the FIFO is full (bb_ready=0).

## Timing
- Reset values:
  - eoc=0, I_IF=0, Q_IF=0, underflow=0.
  - bb_ready=0 while reset_n=0; 1 on the first edge after release.
  - cnt=0, p=0, FIFO empty.
- First eoc: on the DIV-th rising edge after reset_n deasserts (edges 1..DIV-1 advance cnt).
- After that, eoc is high exactly 1 cycle in every DIV.
- I_IF/Q_IF hold their value between ticks.
- Latency: a sample pushed on edge t appears at the first tick edge strictly after t.
- Reset asserted mid-operation:
  - Immediately clears all outputs and FIFO contents, asynchronously.
  - Phase and counter restart as from power-up.

## Configuration
- IQ_MOD_UNDERFLOW_HOLD_EN
  - Defined: on underflow, the last popped baseband sample is re-mixed with the current phase and output. The held sample is (0,0) after reset. underflow still pulses.
  - Undefined: underflow ticks output I_IF=Q_IF=0.

## Test plan
- Reset release, no traffic, DIV=5:
  - eoc pulses on edges 5, 10, 15 after release.
  - underflow pulses with each eoc; I_IF=Q_IF=0.
- Push (I,Q)=(0x70,0x20) four times before the first tick:
  - bb_ready drops after the 4th push.
  - Ticks output (7,2), (−2,7), (−7,−2), (2,−7).
  - bb_ready returns 1 the cycle after the first pop.
- Saturation:
  - Push (127,−128) at p=0 → (7,−8).
  - At p=1 → (7,7), since −(−128) saturates to 7.
  - Rounding: (0x07,0x08) at p=0 → (0,1).
- bb_valid held high with a continuous source:
  - No underflow after the first sample arrives.
  - Exactly one push per tick in steady state.
- Push coinciding with a tick edge on an empty FIFO:
  - That tick underflows.
  - The sample appears on the next tick, with p advanced by 1.
- Assert reset_n mid-stream with 3 entries queued:
  - Outputs go to 0 immediately.
  - After release, the first tick underflows; no stale sample is emitted.

Source files
------------

// File: rtl/iq_mod_if.sv
// iq_mod_if: baseband sample handshake in, paced 4-bit IF samples out.
interface iq_mod_if;
    logic signed [7:0] I_BB;
    logic signed [7:0] Q_BB;
    logic              bb_valid;
    logic              bb_ready;
    logic              eoc;
    logic signed [3:0] I_IF;
    logic signed [3:0] Q_IF;
    logic              underflow;
    modport slave (input I_BB, Q_BB, bb_valid, output bb_ready, eoc, I_IF, Q_IF, underflow);
    modport master(output I_BB, Q_BB, bb_valid, input bb_ready, eoc, I_IF, Q_IF, underflow);
endinterface

// File: rtl/iq_mod.sv
// iq_mod: buffers baseband I/Q, mixes to fs/4 and emits 4-bit IF samples every DIV clocks.
// Define IQ_MOD_UNDERFLOW_HOLD_EN to re-mix the last popped sample on underflow ticks.
module iq_mod #(
    parameter int DIV        = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic     clk,
    input  logic     reset_n,
    iq_mod_if.slave  bb
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(DIV);

    logic        [CW-1:0] r_cnt;
    logic        [1:0]    r_ph;
    logic signed [7:0]    r_mem_i [FIFO_DEPTH];
    logic signed [7:0]    r_mem_q [FIFO_DEPTH];
    logic        [AW-1:0] r_wr;
    logic        [AW-1:0] r_rd;
    logic        [AW:0]   r_count;
    logic                 r_ready;
    logic                 r_eoc;
    logic                 r_uf;
    logic signed [3:0]    r_i_if;
    logic signed [3:0]    r_q_if;

    logic                 w_tick;
    logic                 w_push;
    logic                 w_empty;
    logic                 w_pop;
    logic        [AW:0]   w_count_nx;
    logic signed [7:0]    w_src_i;
    logic signed [7:0]    w_src_q;
    logic signed [8:0]    w_i9;
    logic signed [8:0]    w_q9;
    logic signed [8:0]    w_mix_i;
    logic signed [8:0]    w_mix_q;

    // Round half up then clamp; operand is 9 bits so -(-128) survives negation.
    function automatic logic signed [3:0] quant(input logic signed [8:0] x);
        logic signed [9:0] w;
        w = ($signed({x[8], x}) + 10'sd8) >>> 4;
        return (w > 10'sd7) ? 4'sb0111 : (w < -10'sd8) ? 4'sb1000 : w[3:0];
    endfunction

    assign w_tick     = r_cnt == CW'(DIV - 1);
    assign w_push     = bb.bb_valid && r_ready;
    assign w_empty    = r_count == '0;
    assign w_pop      = w_tick && !w_empty;
    assign w_count_nx = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);

`ifdef IQ_MOD_UNDERFLOW_HOLD_EN
    logic signed [7:0] r_hold_i;
    logic signed [7:0] r_hold_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hold_i <= '0;
            r_hold_q <= '0;
        end else if (w_pop) begin
            r_hold_i <= r_mem_i[r_rd];
            r_hold_q <= r_mem_q[r_rd];
        end
    end

    assign w_src_i = w_empty ? r_hold_i : r_mem_i[r_rd];
    assign w_src_q = w_empty ? r_hold_q : r_mem_q[r_rd];
`else
    assign w_src_i = w_empty ? 8'sd0 : r_mem_i[r_rd];
    assign w_src_q = w_empty ? 8'sd0 : r_mem_q[r_rd];
`endif

    assign w_i9    = {w_src_i[7], w_src_i};
    assign w_q9    = {w_src_q[7], w_src_q};
    assign w_mix_i = (r_ph == 2'd0) ? w_i9 : (r_ph == 2'd1) ? -w_q9 : (r_ph == 2'd2) ? -w_i9 : w_q9;
    assign w_mix_q = (r_ph == 2'd0) ? w_q9 : (r_ph == 2'd1) ? w_i9 : (r_ph == 2'd2) ? -w_q9 : -w_i9;

    // Storage needs no reset: the cleared count makes old entries unreachable.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_i[r_wr] <= bb.I_BB;
            r_mem_q[r_wr] <= bb.Q_BB;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt   <= '0;
            r_ph    <= '0;
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_ready <= 1'b0;
            r_eoc   <= 1'b0;
            r_uf    <= 1'b0;
            r_i_if  <= '0;
            r_q_if  <= '0;
        end else begin
            r_cnt   <= w_tick ? '0 : r_cnt + CW'(1);
            r_eoc   <= w_tick;
            r_uf    <= w_tick && w_empty;
            r_count <= w_count_nx;
            r_ready <= w_count_nx != (AW+1)'(FIFO_DEPTH);
            if (w_tick) begin
                r_ph   <= r_ph + 2'd1;
                r_i_if <= quant(w_mix_i);
                r_q_if <= quant(w_mix_q);
            end
            if (w_push)
                r_wr <= r_wr + AW'(1);
            if (w_pop)
                r_rd <= r_rd + AW'(1);
        end
    end

    assign bb.bb_ready  = r_ready;
    assign bb.eoc       = r_eoc;
    assign bb.I_IF      = r_i_if;
    assign bb.Q_IF      = r_q_if;
    assign bb.underflow = r_uf;
endmodule

// File: tb/tb_iq_mod.sv
// tb_iq_mod: directed vector table plus hand-written sequences for iq_mod (DIV=5, depth 4).
module tb_iq_mod;
    localparam int DIV = 5;

    typedef struct {
        logic signed [7:0] i;
        logic signed [7:0] q;
        int                p;
        int                ei;
        int                eq;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   edge_n = 0;
    int   n_ticks = 0;
    vec_t vecs [10];

    always #5 clk = ~clk;

    iq_mod_if bb();

    iq_mod #(.DIV(DIV), .FIFO_DEPTH(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bb      (bb)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // One clock; eoc must be high exactly on every DIV-th edge since release.
    task automatic step();
        @(posedge clk);
        #1;
        edge_n++;
        if (edge_n % DIV == 0)
            n_ticks++;
        chk("eoc_cadence", bb.eoc, int'(edge_n % DIV == 0));
    endtask

    task automatic to_tick();
        do step(); while (edge_n % DIV != 0);
    endtask

    // Stop on a tick after which the next tick will use phase p.
    task automatic to_tick_phase(input int p);
        do step(); while (!(edge_n % DIV == 0 && n_ticks % 4 == p));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_eoc"}, bb.eoc, 0);
        chk({tag, "_i"}, bb.I_IF, 0);
        chk({tag, "_q"}, bb.Q_IF, 0);
        chk({tag, "_uf"}, bb.underflow, 0);
        chk({tag, "_ready"}, bb.bb_ready, 0);
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        edge_n = 0;
        n_ticks = 0;
    endtask

    task automatic idle_underflow(input int last_edge, input string tag);
        step();
        chk({tag, "_ready_rel"}, bb.bb_ready, 1);
        while (edge_n < last_edge) begin
            step();
            if (edge_n % DIV == 0) begin
                chk({tag, "_uf"}, bb.underflow, 1);
                chk({tag, "_i"}, bb.I_IF, 0);
                chk({tag, "_q"}, bb.Q_IF, 0);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int pushes;
        int ufs;
        logic w;
        vecs[0] = '{8'sh70, 8'sh20, 0, 7, 2};
        vecs[1] = '{8'sh70, 8'sh20, 1, -2, 7};
        vecs[2] = '{8'sh70, 8'sh20, 2, -7, -2};
        vecs[3] = '{8'sh70, 8'sh20, 3, 2, -7};
        vecs[4] = '{8'sh7f, 8'sh80, 0, 7, -8};
        vecs[5] = '{8'sh7f, 8'sh80, 1, 7, 7};
        vecs[6] = '{8'sh07, 8'sh08, 0, 0, 1};
        vecs[7] = '{8'sh7f, 8'sh80, 2, -8, 7};
        vecs[8] = '{8'sh7f, 8'sh80, 3, -8, -8};
        vecs[9] = '{8'sh80, 8'sh80, 2, 7, 7};
        bb.bb_valid = 1'b0;
        bb.I_BB = '0;
        bb.Q_BB = '0;
        #1 reset_n = 1'b0;
        #2 check_reset_outputs("rst");
        release_reset();
        idle_underflow(15, "idle");

        foreach (vecs[k]) begin
            to_tick_phase(vecs[k].p);
            bb.I_BB = vecs[k].i;
            bb.Q_BB = vecs[k].q;
            bb.bb_valid = 1'b1;
            step();
            bb.bb_valid = 1'b0;
            to_tick();
            chk($sformatf("vec%0d_i", k), bb.I_IF, vecs[k].ei);
            chk($sformatf("vec%0d_q", k), bb.Q_IF, vecs[k].eq);
            chk($sformatf("vec%0d_uf", k), bb.underflow, 0);
        end

        // Fill all four slots between two ticks, then drain through every phase.
        to_tick_phase(0);
        bb.I_BB = 8'sh70;
        bb.Q_BB = 8'sh20;
        bb.bb_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("fill%0d_ready", k), bb.bb_ready, int'(k < 3));
        end
        bb.bb_valid = 1'b0;
        for (int t = 0; t < 4; t++) begin
            to_tick();
            chk($sformatf("drain%0d_i", t), bb.I_IF, vecs[t].ei);
            chk($sformatf("drain%0d_q", t), bb.Q_IF, vecs[t].eq);
            if (t == 0)
                chk("ready_after_pop", bb.bb_ready, 1);
        end
        to_tick();
        chk("drain_empty_uf", bb.underflow, 1);

        // Continuous source: never starves, one push per tick once full.
        to_tick();
        bb.I_BB = 8'sh30;
        bb.Q_BB = 8'sh30;
        bb.bb_valid = 1'b1;
        pushes = 0;
        ufs = 0;
        for (int i = 0; i < 40; i++) begin
            w = bb.bb_valid && bb.bb_ready;
            step();
            if (i >= 20 && w)
                pushes++;
            if (bb.underflow)
                ufs++;
        end
        chk("cont_underflows", ufs, 0);
        chk("cont_pushes", pushes, 4);
        bb.bb_valid = 1'b0;
        repeat (6) to_tick();

        // Push on the very edge of a tick with the FIFO empty.
        to_tick_phase(1);
        repeat (DIV - 1) step();
        bb.I_BB = 8'sh70;
        bb.Q_BB = 8'sh20;
        bb.bb_valid = 1'b1;
        step();
        bb.bb_valid = 1'b0;
        chk("coin_tick_uf", bb.underflow, 1);
        chk("coin_tick_i", bb.I_IF, 0);
        chk("coin_tick_q", bb.Q_IF, 0);
        to_tick();
        chk("coin_next_uf", bb.underflow, 0);
        chk("coin_next_i", bb.I_IF, -7);
        chk("coin_next_q", bb.Q_IF, -2);

        // Reset with three entries queued and a nonzero output held.
        bb.bb_valid = 1'b1;
        repeat (3) step();
        bb.bb_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("midrst");
        release_reset();
        idle_underflow(10, "postrst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
